// File: rtl/serial_load_rx.sv
// Framed serial receiver for the counter's load/config registers.
// Define SERIAL_LOAD_RX_PARITY_EN to add the even-parity bit and PARITY state.
module serial_load_rx (
  input  logic       sclk,
  input  logic       arst_n,
  input  logic       cs_n,
  input  logic       sdi,
  output logic [7:0] load_value,
  output logic [7:0] cfg_value,
  output logic       value_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       sdo
);

`ifdef SERIAL_LOAD_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, OPCODE, DATA, PARITY, HOLD
  } state_t;
  logic [7:0] data_sr;
  logic       par_acc;
`else
  typedef enum logic [2:0] {
    IDLE, OPCODE, DATA, HOLD
  } state_t;
  logic [6:0] data_sr;
`endif

  state_t     state, state_nx;
  logic [3:0] bit_cnt;
  logic [1:0] op_r;
  logic [7:0] tx_shift;
  logic [7:0] commit_data;
  logic       last_data;
  logic       final_bit;
  logic       par_ok;
  logic       commit;
  logic       reject;

  always_ff @(posedge sclk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    last_data = (state == DATA) && (bit_cnt == 4'd7);
    if (cs_n) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = OPCODE;
        OPCODE:  state_nx = DATA;
`ifdef SERIAL_LOAD_RX_PARITY_EN
        DATA:    if (last_data) state_nx = PARITY;
        PARITY:  state_nx = HOLD;
`else
        DATA:    if (last_data) state_nx = HOLD;
`endif
        HOLD:    state_nx = HOLD;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The final sampled bit completes the frame; decide commit vs. error here.
  always_comb begin
`ifdef SERIAL_LOAD_RX_PARITY_EN
    final_bit   = !cs_n && (state == PARITY);
    commit_data = data_sr;
    par_ok      = ~(par_acc ^ sdi);
`else
    final_bit   = !cs_n && last_data;
    commit_data = {data_sr, sdi};
    par_ok      = 1'b1;
`endif
    commit = final_bit && (op_r != 2'b11) && par_ok;
    reject = final_bit && !commit;
  end

  always_ff @(posedge sclk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt     <= '0;
      op_r        <= '0;
      data_sr     <= '0;
      tx_shift    <= '0;
      load_value  <= '0;
      cfg_value   <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SERIAL_LOAD_RX_PARITY_EN
      par_acc     <= 1'b0;
`endif
    end else begin
      if (!cs_n) begin
        unique case (state)
          IDLE: begin
            op_r[1] <= sdi;
            bit_cnt <= '0;
          end
          OPCODE: begin
            op_r[0]  <= sdi;
            bit_cnt  <= '0;
            tx_shift <= load_value;
          end
          DATA: begin
            data_sr  <= {data_sr[$bits(data_sr)-2:0], sdi};
            tx_shift <= {tx_shift[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 4'd1;
          end
          default: ;
        endcase
`ifdef SERIAL_LOAD_RX_PARITY_EN
        par_acc <= (state == IDLE) ? sdi : (par_acc ^ sdi);
`endif
      end
      if (commit) begin
        frame_err <= 1'b0;
        if (op_r == 2'b00) begin
          load_value  <= commit_data;
          value_valid <= 1'b1;
        end
        if (op_r == 2'b01) cfg_value <= commit_data;
      end
      if (reject) frame_err <= 1'b1;
    end
  end

  assign busy = (state != IDLE);
  assign sdo  = (state == DATA) & tx_shift[7];

endmodule
